// File: rtl/mem_io_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_io_bus_ctrl: arbiter/sequencer for the shared data-RAM and LED/switch   |
// | IO bus. Optional macro ARB_RR_EN: alternate the grant on contention.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_io_bus_ctrl #(
  parameter int          RD_LAT = 1,
  parameter int          MEM_AW = 14,
  parameter logic [23:0] IO_TAG = 24'hFFFFFC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  input  logic              uart_req,
  input  logic [MEM_AW-1:0] uart_addr,
  input  logic [31:0]       uart_wdata,
  output logic              uart_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              led_wen,
  output logic [15:0]       led_wdata,
  input  logic [15:0]       sw_data
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam logic SRC_CPU  = 1'b0;
  localparam logic SRC_UART = 1'b1;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        src_q, src_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        grant_uart;
  logic        is_io, is_led, is_sw;
  logic        done;
  logic        rd_fire;
  logic [31:0] rd_val;
  logic        unused_addr_lsb;

  // Byte-lane bits never reach the word-addressed bus.
  assign unused_addr_lsb = ^cpu_addr[1:0];

`ifdef ARB_RR_EN
  logic last_q, last_d;
  assign grant_uart = uart_req && (!cpu_req || (last_q == SRC_CPU));
`else
  assign grant_uart = uart_req;
`endif

  // UART accesses are forced to the memory region regardless of address.
  assign is_io  = (src_q == SRC_CPU) && (addr_q[31:8] == IO_TAG);
  assign is_led = is_io && (addr_q[7:4] == 4'h6);
  assign is_sw  = is_io && (addr_q[7:4] == 4'h7);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
`ifdef ARB_RR_EN
    last_d    = last_q;
`endif
    done      = 1'b0;
    rd_fire   = 1'b0;
    rd_val    = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    led_wen   = 1'b0;
    led_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || uart_req) begin
          state_d = ST_ACCESS;
          if (grant_uart) begin
            src_d   = SRC_UART;
            addr_d  = {{(30-MEM_AW){1'b0}}, uart_addr};
            wdata_d = uart_wdata;
            we_d    = 1'b1;
          end else begin
            src_d   = SRC_CPU;
            addr_d  = cpu_addr[31:2];
            wdata_d = cpu_wdata;
            we_d    = cpu_we;
          end
`ifdef ARB_RR_EN
          if (cpu_req && uart_req) begin
            last_d = grant_uart ? SRC_UART : SRC_CPU;
          end
`endif
        end
      end

      ST_ACCESS: begin
        if (!is_io) begin
          mem_en   = 1'b1;
          mem_addr = addr_q[MEM_AW+1:2];
          if (we_q) begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
            done      = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = ST_WAIT;
          end
        end else begin
          done    = 1'b1;
          state_d = ST_IDLE;
          if (we_q && is_led) begin
            led_wen   = 1'b1;
            led_wdata = wdata_q[15:0];
          end
          if (!we_q) begin
            rd_fire = 1'b1;
            rd_val  = is_sw ? {16'h0, sw_data} : 32'h0;
          end
        end
      end

      ST_WAIT: begin
        mem_en   = 1'b1;
        mem_addr = addr_q[MEM_AW+1:2];
        if (cnt_q == 2'd0) begin
          done    = 1'b1;
          rd_fire = 1'b1;
          rd_val  = mem_rdata;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (rd_fire) begin
      rdata_d = rd_val;
    end
  end

  // Read data is forwarded in the completion cycle and held afterwards.
  assign cpu_rdata = rd_fire ? rd_val : rdata_q;
  assign cpu_done  = done && (src_q == SRC_CPU);
  assign uart_ack  = done && (src_q == SRC_UART);
  assign cpu_stall = rst_n && cpu_req && !cpu_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      src_q   <= SRC_CPU;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef ARB_RR_EN
      last_q  <= SRC_CPU;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_io_bus_ctrl: directed + randomized bench with a reference model.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_io_bus_ctrl;

  localparam int          RD_LAT = 2;
  localparam int          MEM_AW = 14;
  localparam logic [23:0] IO_TAG = 24'hFFFFFC;

  logic              clk;
  logic              rst_n;
  logic              cpu_req, cpu_we;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic              cpu_stall, cpu_done;
  logic              uart_req;
  logic [MEM_AW-1:0] uart_addr;
  logic [31:0]       uart_wdata;
  logic              uart_ack;
  logic              mem_en, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              led_wen;
  logic [15:0]       led_wdata, sw_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [0:63];
  logic [31:0] last_rd;
  bit          last_win_uart;
  logic        ram_clr;

  mem_io_bus_ctrl #(.RD_LAT(RD_LAT), .MEM_AW(MEM_AW), .IO_TAG(IO_TAG)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
    .uart_req(uart_req), .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_ack(uart_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .led_wen(led_wen), .led_wdata(led_wdata), .sw_data(sw_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with RD_LAT cycles of read latency; garbage when not read.
  logic [31:0] ram  [0:63];
  logic [31:0] pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
    end else if (mem_en && mem_we) begin
      ram[mem_addr[5:0]] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[5:0]] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One CPU access; caller is just past a rising edge with the bus idle.
  task automatic cpu_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bit          io, seen;
    logic [3:0]  off;
    int          lat_exp, k;
    logic [31:0] rd_exp;
    io      = (addr[31:8] == IO_TAG);
    off     = addr[7:4];
    lat_exp = (!io && !we) ? 1 + RD_LAT : 1;
    rd_exp  = io ? ((off == 4'h7) ? {16'h0, sw_data} : 32'h0) : ref_mem[addr[7:2]];
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    seen = 0;
    k    = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      chk("cpu_stall", {31'h0, cpu_stall}, {31'h0, k < lat_exp});
      if (!we) chk("load_mem_we", {31'h0, mem_we}, 32'h0);
      if (cpu_done) begin
        seen = 1;
        chk("cpu_latency", k, lat_exp);
        if (!we) chk("cpu_rdata", cpu_rdata, rd_exp);
        if (!io) begin
          chk("mem_en", {31'h0, mem_en}, 32'h1);
          chk("mem_addr", {18'h0, mem_addr}, {18'h0, addr[MEM_AW+1:2]});
          if (we) chk("mem_wdata", mem_wdata, wdata);
        end else begin
          chk("io_mem_en", {31'h0, mem_en}, 32'h0);
          chk("led_wen", {31'h0, led_wen}, {31'h0, we && off == 4'h6});
          if (we && off == 4'h6) chk("led_wdata", {16'h0, led_wdata}, {16'h0, wdata[15:0]});
        end
      end
      next_cycle();
      k++;
    end
    if (!seen) chk("cpu_done_timeout", 32'h0, 32'h1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    if (!we) last_rd = rd_exp;
    if (we && !io) ref_mem[addr[7:2]] = wdata;
    @(negedge clk);
    chk("rdata_hold", cpu_rdata, last_rd);
    next_cycle();
  endtask

  task automatic uart_txn(input logic [MEM_AW-1:0] a, input logic [31:0] d);
    bit seen;
    int k;
    uart_req = 1'b1; uart_addr = a; uart_wdata = d;
    seen = 0;
    k    = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (uart_ack) begin
        seen = 1;
        chk("uart_latency", k, 1);
        chk("uart_mem_we", {31'h0, mem_we}, 32'h1);
        chk("uart_mem_addr", {18'h0, mem_addr}, {18'h0, a});
        chk("uart_mem_wdata", mem_wdata, d);
      end
      next_cycle();
      k++;
    end
    if (!seen) chk("uart_ack_timeout", 32'h0, 32'h1);
    uart_req = 1'b0;
    ref_mem[a[5:0]] = d;
  endtask

  // Simultaneous CPU store and UART write to distinct words.
  task automatic contend(input logic [31:0] caddr, input logic [31:0] cw,
                         input logic [MEM_AW-1:0] ua, input logic [31:0] uw);
    bit uart_first, cs, us;
    int k, c_cyc, u_cyc;
`ifdef ARB_RR_EN
    uart_first    = !last_win_uart;
    last_win_uart = uart_first;
`else
    uart_first = 1;
`endif
    u_cyc = uart_first ? 1 : 3;
    c_cyc = uart_first ? 3 : 1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = caddr; cpu_wdata = cw;
    uart_req = 1'b1; uart_addr = ua; uart_wdata = uw;
    cs = 0; us = 0; k = 0;
    while (!(cs && us) && k < 20) begin
      @(negedge clk);
      chk("arb_stall", {31'h0, cpu_stall}, {31'h0, k < c_cyc});
      if (uart_ack) begin
        us = 1;
        chk("arb_uart_cycle", k, u_cyc);
        chk("arb_uart_addr", {18'h0, mem_addr}, {18'h0, ua});
        chk("arb_uart_wdata", mem_wdata, uw);
      end
      if (cpu_done) begin
        cs = 1;
        chk("arb_cpu_cycle", k, c_cyc);
        chk("arb_cpu_addr", {18'h0, mem_addr}, {18'h0, caddr[MEM_AW+1:2]});
        chk("arb_cpu_wdata", mem_wdata, cw);
      end
      next_cycle();
      if (us) uart_req = 1'b0;
      if (cs) begin cpu_req = 1'b0; cpu_we = 1'b0; end
      k++;
    end
    if (!(cs && us)) chk("arb_timeout", 32'h0, 32'h1);
    cpu_req = 1'b0; uart_req = 1'b0;
    ref_mem[ua[5:0]]     = uw;
    ref_mem[caddr[7:2]]  = cw;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_done"}, {31'h0, cpu_done}, 32'h0);
    chk({tag, "_cpu_stall"}, {31'h0, cpu_stall}, 32'h0);
    chk({tag, "_uart_ack"}, {31'h0, uart_ack}, 32'h0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk({tag, "_mem_ctl"}, {30'h0, mem_en, mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, {18'h0, mem_addr}, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_led"}, {15'h0, led_wen, led_wdata}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    int          r;
    logic [3:0]  off;
    rst_n = 1'b0; ram_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    uart_req = 1'b0; uart_addr = '0; uart_wdata = '0; sw_data = '0;
    last_rd = '0; last_win_uart = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    cpu_req = 1'b0;
    next_cycle();
    rst_n = 1'b1; ram_clr = 1'b0;
    next_cycle();

    // Directed accesses from the test plan.
    cpu_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    cpu_txn(1'b0, 32'h0000_0010, 32'h0);
    cpu_txn(1'b1, 32'hFFFF_FC60, 32'h0000_A5A5);
    sw_data = 16'h1234;
    cpu_txn(1'b0, 32'hFFFF_FC70, 32'h0);
    cpu_txn(1'b0, 32'hFFFF_FC80, 32'h0);
    cpu_txn(1'b0, 32'h0000_0010, 32'h0);

    contend(32'h0000_0020, 32'h1111_2222, 14'd7, 32'h3333_4444);
    contend(32'h0000_0024, 32'h5555_6666, 14'd10, 32'h7777_8888);
    cpu_txn(1'b0, 32'h0000_001C, 32'h0);
    cpu_txn(1'b0, 32'h0000_0024, 32'h0);

    // Randomized mix, all checked against the reference model.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      a = {24'h0, 2'b00, 6'($urandom_range(0, 15)), 2'($urandom)};
      d = $urandom;
      sw_data = 16'($urandom);
      case (r)
        0, 1, 2: cpu_txn(1'b1, a, d);
        3, 4, 5: cpu_txn(1'b0, a, 32'h0);
        6:       cpu_txn(1'b1, {IO_TAG, 4'h6, 4'($urandom)}, d);
        7:       cpu_txn(1'b0, {IO_TAG, 4'h7, 4'($urandom)}, 32'h0);
        8: begin
          off = 4'($urandom_range(0, 13));
          if (off >= 4'h6) off = off + 4'h2;
          cpu_txn(1'($urandom), {IO_TAG, off, 4'($urandom)}, d);
        end
        default: uart_txn(14'($urandom_range(0, 15)), d);
      endcase
      repeat ($urandom_range(0, 1)) next_cycle();
    end

    // Reset while a load sits in WAIT: nothing completes, all outputs clear.
    cpu_txn(1'b1, 32'h0000_0014, 32'hCAFE_F00D);
    cpu_txn(1'b0, 32'h0000_0014, 32'h0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0018;
    next_cycle();
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) begin
      @(negedge clk);
      chk("midreset_no_done", {31'h0, cpu_done}, 32'h0);
    end
    next_cycle();
    rst_n = 1'b1; cpu_req = 1'b0;
    last_rd = 32'h0; last_win_uart = 0;
    next_cycle();
    cpu_txn(1'b0, 32'h0000_0014, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
